// File: rtl/sdram_rmw_engine_pkg.sv
// Shared encodings for the SDRAM read-modify-write engine:
// controller command codes, transform modes and the engine state type.
package sdram_rmw_engine_pkg;

    // Controller command encodings
    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    // Lane transform modes
    localparam logic [1:0] MODE_ADD    = 2'd0;
    localparam logic [1:0] MODE_SUB    = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;
    localparam logic [1:0] MODE_PASS   = 2'd3;

    // Engine states share their encoding with the command they drive
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } rmw_state_t;

endpackage

// File: rtl/rmw_fifo.sv
// Show-ahead FIFO (DATA_W x DEPTH) holding one burst between its read and
// write phases. o_Q always presents the head word. Pushes while full and
// pops while empty are ignored; the caller flags them.
module rmw_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Push,
    input  logic              i_Pop,
    input  logic [DATA_W-1:0] i_Data,
    output logic [DATA_W-1:0] o_Q,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0] o_Usedw
);

    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int USEDW_W = AW + 1;

    logic [DATA_W-1:0]  mem [0:(1 << AW)-1];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [USEDW_W-1:0] count_reg;
    logic               do_push;
    logic               do_pop;

    assign o_Full  = (count_reg == USEDW_W'(DEPTH));
    assign o_Empty = (count_reg == '0);
    assign o_Usedw = count_reg;
    assign do_push = i_Push && !o_Full;
    assign do_pop  = i_Pop && !o_Empty;
    assign o_Q     = mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; reset flushes the FIFO
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + USEDW_W'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - USEDW_W'(1);
        end
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge i_Clk) begin
        if (do_push) mem[wr_ptr_reg] <= i_Data;
    end

endmodule

// File: rtl/sdram_rmw_engine.sv
// Read-modify-write SDRAM client. Walks a frame region one burst at a
// time: burst-read into a local FIFO, transform each word lane-wise, then
// burst-write back to the same addresses. Yields the shared bus only
// between bursts.
// Build option: define RMW_SATURATE_EN to make ADD/SUB clamp per lane
// instead of wrapping.
module sdram_rmw_engine
    import sdram_rmw_engine_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LANE_W       = 8,
    parameter int ADDR_W       = 22,
    parameter int BURST_LEN    = 8,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_WORDS = 96000,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Enable,
    input  logic [1:0]        i_Mode,
    input  logic [LANE_W-1:0] i_Operand,
    input  logic              i_SDRAM_Requested,
    output logic              o_SDRAM_Yield,
    output logic [1:0]        o_Command,
    output logic [ADDR_W-1:0] o_Data_Address,
    input  logic              i_Data_Read_Valid,
    input  logic [DATA_W-1:0] i_Data_Read,
    input  logic              i_Data_Write_Done,
    output logic [DATA_W-1:0] o_Data_Write,
    output logic              o_Frame_Done,
    output logic              o_Error
);

    localparam int LANES   = DATA_W / LANE_W;
    localparam int CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    // Base of the final burst; compared instead of base+BURST_LEN==end to
    // avoid overflow at the top of the address space
    localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'(BASE_ADDR + REGION_WORDS - BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);

    rmw_state_t        state_reg, state_next;
    rmw_state_t        next_op_reg, next_op_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              frame_done_reg, frame_done_next;
    logic              error_reg;
    logic [1:0]        mode_reg;
    logic [LANE_W-1:0] operand_reg;
    logic              latch_cfg;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  unused_fifo_usedw;

    // One lane of the transform, modulo 2^LANE_W unless saturating
    function automatic logic [LANE_W-1:0] lane_xform(
        input logic [LANE_W-1:0] lane,
        input logic [1:0]        mode,
        input logic [LANE_W-1:0] op
    );
        logic [LANE_W-1:0] res;
`ifdef RMW_SATURATE_EN
        logic [LANE_W:0]   sum;
        sum = {1'b0, lane} + {1'b0, op};
`endif
        case (mode)
`ifdef RMW_SATURATE_EN
            MODE_ADD:    res = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
            MODE_SUB:    res = (lane < op) ? '0 : lane - op;
`else
            MODE_ADD:    res = lane + op;
            MODE_SUB:    res = lane - op;
`endif
            MODE_INVERT: res = ~lane;
            default:     res = lane;
        endcase
        return res;
    endfunction

    rmw_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Push  (fifo_push),
        .i_Pop   (fifo_pop),
        .i_Data  (i_Data_Read),
        .o_Q     (fifo_q),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty),
        .o_Usedw (unused_fifo_usedw)
    );

    assign o_Command      = state_reg;
    assign o_Data_Address = addr_reg;
    assign o_Frame_Done   = frame_done_reg;
    assign o_Error        = error_reg;
    assign o_SDRAM_Yield  = i_SDRAM_Requested && (o_Command == CMD_IDLE);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign o_Data_Write[gi*LANE_W +: LANE_W] =
            lane_xform(fifo_q[gi*LANE_W +: LANE_W], mode_reg, operand_reg);
    end

    // Burst sequencing: next state, address, base and beat counter
    always_comb begin
        state_next      = state_reg;
        next_op_next    = next_op_reg;
        addr_next       = addr_reg;
        base_next       = base_reg;
        cnt_next        = cnt_reg;
        frame_done_next = 1'b0;
        latch_cfg       = 1'b0;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A pending write always finishes so the FIFO never parks full;
                // a bus request still takes priority
                if (!i_SDRAM_Requested && (i_Enable || next_op_reg == ST_WRITE)) begin
                    state_next = next_op_reg;
                    addr_next  = base_reg;
                    cnt_next   = CNT_LAST;
                    // One transform per frame: sample config at the first read
                    if (next_op_reg == ST_READ && base_reg == BASE) latch_cfg = 1'b1;
                end
            end
            ST_READ: begin
                if (i_Data_Read_Valid) begin
                    fifo_push = 1'b1;
                    addr_next = addr_reg + ADDR_W'(1);
                    if (cnt_reg == '0) begin
                        state_next   = ST_IDLE;
                        next_op_next = ST_WRITE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (i_Data_Write_Done) begin
                    fifo_pop  = 1'b1;
                    addr_next = addr_reg + ADDR_W'(1);
                    if (cnt_reg == '0) begin
                        state_next   = ST_IDLE;
                        next_op_next = ST_READ;
                        if (base_reg == LAST_BASE) begin
                            base_next       = BASE;
                            frame_done_next = 1'b1;
                        end else begin
                            base_next = base_reg + BURST_STEP;
                        end
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any burst in flight
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg      <= ST_IDLE;
            next_op_reg    <= ST_READ;
            addr_reg       <= BASE;
            base_reg       <= BASE;
            cnt_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            next_op_reg    <= next_op_next;
            addr_reg       <= addr_next;
            base_reg       <= base_next;
            cnt_reg        <= cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Frame-wide transform configuration
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            mode_reg    <= MODE_PASS;
            operand_reg <= '0;
        end else if (latch_cfg) begin
            mode_reg    <= i_Mode;
            operand_reg <= i_Operand;
        end
    end

    // Sticky FIFO misuse flag: overflow or pop while empty
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            error_reg <= 1'b0;
        end else if ((fifo_push && fifo_full) || (fifo_pop && fifo_empty)) begin
            error_reg <= 1'b1;
        end
    end

endmodule
